// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Stall bus bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; a set bit holds that stage.
package stall_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_MEMW = 6'b011111;  // PC..MEM held, bubble into WB
    localparam stall_bus_t STALL_DIVW = 6'b001111;  // PC..EX held, bubble into MEM
    localparam stall_bus_t STALL_LU   = 6'b000111;  // PC/IF/ID held, bubble into EX

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    // True when an enabled ID source operand matches the EX destination.
    function automatic logic src_hit(input logic [4:0] src, input logic re,
                                     input logic [4:0] waddr);
        return re & (src == waddr);
    endfunction

endpackage

// File: rtl/stall_div_counter.sv
// Divide-occupancy counter: loads DIV_CYCLES-1 on an accepted start, then counts
// down to zero regardless of other pipeline activity.
module stall_div_counter #(
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a start while already counting is a protocol error and is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (start && (cnt_q == '0)) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0) | start;
    assign done = (cnt_q == CNT_ONE);

endmodule

// File: rtl/stall_ctrl.sv
// Central hazard scheduler: merges load-use, divide occupancy and data-SRAM wait into
// the shared stall bus. Optional build macro STALL_CTRL_PERF_EN adds per-pattern
// stall-cycle counters.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_rs_re,
    input  logic               id_rt_re,
    input  logic               ex_is_load,
    input  logic               ex_rf_we,
    input  logic [4:0]         ex_waddr,
    input  logic               ex_div_start,
    input  logic               mem_req,
    input  logic               mem_ack,
    output logic [STALL_W-1:0] stall,
    output logic               div_busy,
    output logic               div_done
`ifdef STALL_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_lu_cyc,
    output logic [31:0]        perf_div_cyc,
    output logic [31:0]        perf_mem_cyc
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             div_pending_q, div_pending_d;
    logic [CNT_W-1:0] cnt;
    logic             div_start;
    logic             mem_hold;
    logic             div_hold;
    logic             lu_hazard;

    assign div_start = (state_q == ST_RUN) & ex_div_start;

    stall_div_counter #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_counter (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .busy  (div_busy),
        .done  (div_done),
        .cnt   (cnt)
    );

    // Hazard conditions and prioritised stall pattern, all zero-latency.
    always_comb begin
        mem_hold  = mem_req & ~mem_ack;
        div_hold  = div_start | (cnt != '0);
        lu_hazard = ex_is_load & ex_rf_we & (ex_waddr != 5'd0) &
                    (src_hit(id_rs, id_rs_re, ex_waddr) | src_hit(id_rt, id_rt_re, ex_waddr));
        stall = STALL_NONE;
        if (mem_hold) begin
            stall = STALL_MEMW;
        end else if (div_hold) begin
            stall = STALL_DIVW;
        end else if (lu_hazard) begin
            stall = STALL_LU;
        end
    end

    // FSM next state; div_pending records that a divide is still in flight under a mem wait.
    always_comb begin
        state_d       = state_q;
        div_pending_d = div_pending_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_hold) begin
                    state_d       = ST_MEM_WAIT;
                    div_pending_d = div_start | (cnt != '0);
                end else if (div_start && (cnt == '0)) begin
                    state_d = ST_DIV_WAIT;
                end
            end
            ST_DIV_WAIT: begin
                if (mem_hold) begin
                    state_d       = ST_MEM_WAIT;
                    div_pending_d = 1'b1;
                end else if (cnt <= CNT_ONE) begin
                    // <= rather than == so a stray zero count can never trap the FSM
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    state_d       = (div_pending_q && (cnt > CNT_ONE)) ? ST_DIV_WAIT : ST_RUN;
                    div_pending_d = 1'b0;
                end
            end
            default: begin
                state_d       = ST_RUN;
                div_pending_d = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            div_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_pending_q <= div_pending_d;
        end
    end

`ifdef STALL_CTRL_PERF_EN
    logic [31:0] perf_lu_q, perf_div_q, perf_mem_q;

    // Stall-cycle counters, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_q  <= '0;
            perf_div_q <= '0;
            perf_mem_q <= '0;
        end else begin
            if (stall == STALL_LU)   perf_lu_q  <= perf_lu_q + 32'd1;
            if (stall == STALL_DIVW) perf_div_q <= perf_div_q + 32'd1;
            if (stall == STALL_MEMW) perf_mem_q <= perf_mem_q + 32'd1;
        end
    end

    assign perf_lu_cyc  = perf_lu_q;
    assign perf_div_cyc = perf_div_q;
    assign perf_mem_cyc = perf_mem_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl (DIV_CYCLES=33). Inputs change just after
// the falling edge and outputs are sampled 1 ns later, well clear of the rising edge.
module tb_stall_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_MEMW = 6'b011111;
    localparam logic [5:0] S_DIVW = 6'b001111;
    localparam logic [5:0] S_LU   = 6'b000111;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_waddr;
    logic       id_rs_re, id_rt_re, ex_is_load, ex_rf_we, ex_div_start, mem_req, mem_ack;
    logic [5:0] stall;
    logic       div_busy, div_done;
`ifdef STALL_CTRL_PERF_EN
    logic [31:0] perf_lu_cyc, perf_div_cyc, perf_mem_cyc;
    logic [31:0] p0_lu, p0_div, p0_mem;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       ld;
        logic       we;
        logic [4:0] wa;
        logic [4:0] rs;
        logic       rs_re;
        logic [4:0] rt;
        logic       rt_re;
        logic [5:0] exp;
    } lu_vec_t;

    stall_ctrl #(
        .DIV_CYCLES (33),
        .CNT_W      (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_re     (id_rs_re),
        .id_rt_re     (id_rt_re),
        .ex_is_load   (ex_is_load),
        .ex_rf_we     (ex_rf_we),
        .ex_waddr     (ex_waddr),
        .ex_div_start (ex_div_start),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .stall        (stall),
        .div_busy     (div_busy),
        .div_done     (div_done)
`ifdef STALL_CTRL_PERF_EN
        ,
        .perf_lu_cyc  (perf_lu_cyc),
        .perf_div_cyc (perf_div_cyc),
        .perf_mem_cyc (perf_mem_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        id_rs = 5'd0; id_rt = 5'd0; ex_waddr = 5'd0;
        id_rs_re = 1'b0; id_rt_re = 1'b0; ex_is_load = 1'b0; ex_rf_we = 1'b0;
        ex_div_start = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        step();
        #1;
        checks++;
        if (stall !== S_NONE) begin
            failures++; $display("FAIL reset_stall got=%b exp=%b", stall, S_NONE);
        end
        checks++;
        if ({div_busy, div_done} !== 2'b00) begin
            failures++; $display("FAIL reset_div got=%b exp=00", {div_busy, div_done});
        end
        rst = 1'b0;
        // Run a divide to counter=20 (divide cycle 14), then reset asynchronously.
        step();
        ex_div_start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if (i > 1) begin
                step();
                ex_div_start = 1'b0;
            end
            #1;
            checks++;
            if (stall !== S_DIVW) begin
                failures++; $display("FAIL pre_reset_div cyc=%0d got=%b exp=%b", i, stall, S_DIVW);
            end
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (stall !== S_NONE) begin
            failures++; $display("FAIL midreset_stall got=%b exp=%b", stall, S_NONE);
        end
        checks++;
        if ({div_busy, div_done} !== 2'b00) begin
            failures++; $display("FAIL midreset_div got=%b exp=00", {div_busy, div_done});
        end
`ifdef STALL_CTRL_PERF_EN
        checks++;
        if ({perf_lu_cyc, perf_div_cyc, perf_mem_cyc} !== 96'd0) begin
            failures++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0",
                                 perf_lu_cyc, perf_div_cyc, perf_mem_cyc);
        end
`endif
        step();
        rst = 1'b0;
        step();
        // Back in RUN: a new start is accepted and holds the pipe on the following cycle.
        ex_div_start = 1'b1;
        #1;
        checks++;
        if (stall !== S_DIVW) begin
            failures++; $display("FAIL postreset_start got=%b exp=%b", stall, S_DIVW);
        end
        step();
        ex_div_start = 1'b0;
        #1;
        checks++;
        if (stall !== S_DIVW || div_busy !== 1'b1) begin
            failures++; $display("FAIL postreset_accept got=%b/%b exp=%b/1", stall, div_busy, S_DIVW);
        end
        for (int k = 0; k < 40 && div_busy; k++) step();
        checks++;
        if (div_busy !== 1'b0) begin
            failures++; $display("FAIL postreset_drain busy=%b exp=0", div_busy);
        end
        step();
    endtask

    task automatic test_load_use;
        lu_vec_t vecs [7];
        vecs = '{
            '{1'b1, 1'b1, 5'd5,  5'd5, 1'b1, 5'd0,  1'b0, S_LU},
            '{1'b1, 1'b1, 5'd7,  5'd3, 1'b1, 5'd7,  1'b1, S_LU},
            '{1'b1, 1'b1, 5'd7,  5'd3, 1'b1, 5'd7,  1'b0, S_NONE},
            '{1'b1, 1'b0, 5'd5,  5'd5, 1'b1, 5'd0,  1'b0, S_NONE},
            '{1'b0, 1'b1, 5'd5,  5'd5, 1'b1, 5'd0,  1'b0, S_NONE},
            '{1'b1, 1'b1, 5'd0,  5'd0, 1'b1, 5'd0,  1'b1, S_NONE},
            '{1'b1, 1'b1, 5'd9,  5'd8, 1'b1, 5'd10, 1'b1, S_NONE}
        };
`ifdef STALL_CTRL_PERF_EN
        p0_lu = perf_lu_cyc; p0_div = perf_div_cyc; p0_mem = perf_mem_cyc;
`endif
        for (int i = 0; i < 7; i++) begin
            ex_is_load = vecs[i].ld; ex_rf_we = vecs[i].we; ex_waddr = vecs[i].wa;
            id_rs = vecs[i].rs; id_rs_re = vecs[i].rs_re;
            id_rt = vecs[i].rt; id_rt_re = vecs[i].rt_re;
            #1;
            checks++;
            if (stall !== vecs[i].exp) begin
                failures++; $display("FAIL load_use vec=%0d got=%b exp=%b", i, stall, vecs[i].exp);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_divide;
        ex_div_start = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            if (i > 1) begin
                step();
                ex_div_start = 1'b0;
            end
            #1;
            checks++;
            if (stall !== ((i <= 33) ? S_DIVW : S_NONE) || div_busy !== (i <= 33)
                || div_done !== (i == 33)) begin
                failures++;
                $display("FAIL divide cyc=%0d stall=%b busy=%b done=%b exp_done=%0d",
                         i, stall, div_busy, div_done, (i == 33));
            end
        end
        step();
    endtask

    task automatic test_mem_wait;
        for (int i = 1; i <= 6; i++) begin
            mem_req = (i <= 5);
            mem_ack = (i == 5);
            // Load-use hazard in cycle 2 is outranked by the memory wait.
            ex_is_load = (i == 2); ex_rf_we = (i == 2); ex_waddr = 5'd4;
            id_rs = 5'd4; id_rs_re = (i == 2);
            #1;
            checks++;
            if (stall !== ((i <= 4) ? S_MEMW : S_NONE)) begin
                failures++; $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, stall,
                                     (i <= 4) ? S_MEMW : S_NONE);
            end
            if (i < 6) step();
        end
`ifdef STALL_CTRL_PERF_EN
        checks++;
        if (perf_lu_cyc - p0_lu !== 32'd2 || perf_div_cyc - p0_div !== 32'd33
            || perf_mem_cyc - p0_mem !== 32'd4) begin
            failures++; $display("FAIL perf got=%0d/%0d/%0d exp=2/33/4", perf_lu_cyc - p0_lu,
                                 perf_div_cyc - p0_div, perf_mem_cyc - p0_mem);
        end
`endif
        idle_inputs();
        step();
    endtask

    // Divide from cycle 1, memory wait over cycles 10..29, ack in cycle 30 (counter=4).
    task automatic test_div_mem_overlap;
        logic [5:0] exp;
        for (int i = 1; i <= 37; i++) begin
            ex_div_start = (i == 1);
            mem_req      = (i >= 10 && i <= 30);
            mem_ack      = (i == 30);
            if (i >= 10 && i <= 29)  exp = S_MEMW;
            else if (i <= 33)        exp = S_DIVW;
            else                     exp = S_NONE;
            #1;
            checks++;
            if (stall !== exp || div_busy !== (i <= 33) || div_done !== (i == 33)) begin
                failures++;
                $display("FAIL overlap cyc=%0d stall=%b exp=%b busy=%b done=%b",
                         i, stall, exp, div_busy, div_done);
            end
            step();
        end
        // FSM must be back in RUN: a fresh start is accepted.
        ex_div_start = 1'b1;
        step();
        ex_div_start = 1'b0;
        #1;
        checks++;
        if (stall !== S_DIVW || div_busy !== 1'b1) begin
            failures++; $display("FAIL overlap_rerun got=%b/%b exp=%b/1", stall, div_busy, S_DIVW);
        end
        for (int k = 0; k < 40 && div_busy; k++) step();
        checks++;
        if (div_busy !== 1'b0) begin
            failures++; $display("FAIL overlap_drain busy=%b exp=0", div_busy);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_divide();
        test_mem_wait();
        test_div_mem_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
